// File: rtl/fetch_pc_sequencer.sv
// rtl/fetch_pc_sequencer.sv - IF-stage program counter and instruction fetch sequencer
//
// Owns the program counter, selects the next PC (sequential, jump, branch or
// hold) and runs the request/acknowledge handshake with instruction memory.
// The sequential PC comes from the external word incrementer; there is no
// local adder.
//
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-low reset
//   stall                          hazard-unit hold request
//   jump, jump_target              jump redirect pulse and destination
//   branch_taken, branch_target    taken-branch redirect pulse and destination
//   incr_pcin, incr_pcout          external incrementer operand / result
//   imem_req, imem_addr, imem_ack  instruction memory fetch handshake
//   instr_valid, if_pc, if_npc     accepted instruction presented to IF/ID
//   flush                          kill younger pipeline contents
module fetch_pc_sequencer #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] incr_pcin,
   input  logic [WIDTH-1:0] incr_pcout,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   output logic             instr_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_npc,
   output logic             flush
);

   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] pc;
   logic             pending;
   logic [WIDTH-1:0] pendTarget;

   logic             redirect;
   logic [WIDTH-1:0] target;
   logic             inFetch;
   logic             inStall;

   assign redirect = jump | branch_taken;
   // Jump wins over a simultaneous taken branch.
   assign target   = jump ? jump_target : branch_target;
   assign inFetch  = (state == FETCH);
   assign inStall  = (state == STALL);

   assign incr_pcin = pc;
   assign imem_addr = pc;
   assign imem_req  = inFetch;
   assign if_pc     = pc;
   assign if_npc    = incr_pcout;

   // BOOT ignores redirects, so flush only fires in FETCH or STALL.
   assign flush = (inFetch | inStall) & redirect;

   // An acked instruction is only accepted when nothing redirects it away
   // and the hazard unit is not holding the front end.
   assign instr_valid = inFetch & imem_ack & ~redirect & ~pending & ~stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= BOOT;
         pc         <= RESET_PC;
         pending    <= 1'b0;
         pendTarget <= '0;
      end else begin
         case (state)
            BOOT: begin
               state <= FETCH;
            end
            FETCH: begin
               if (!imem_ack) begin
                  // Address must stay stable while the access is in flight,
                  // so a redirect is parked until the ack arrives.
                  if (redirect) begin
                     pendTarget <= target;
                     pending    <= 1'b1;
                  end
               end else if (redirect) begin
                  pc      <= target;
                  pending <= 1'b0;
               end else if (pending) begin
                  pc      <= pendTarget;
                  pending <= 1'b0;
               end else if (stall) begin
                  // Instruction is dropped and re-fetched from the same pc.
                  state <= STALL;
               end else begin
                  pc <= incr_pcout;
               end
            end
            STALL: begin
               if (redirect) begin
                  pc    <= target;
                  state <= FETCH;
               end else if (!stall) begin
                  state <= FETCH;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb/tb_fetch_pc_sequencer.sv - scoreboard bench for fetch_pc_sequencer
module tb_fetch_pc_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         stall = 1'b0;
   logic         jump = 1'b0;
   logic         branch_taken = 1'b0;
   logic         imem_ack = 1'b0;
   logic [W-1:0] jump_target = '0;
   logic [W-1:0] branch_target = '0;
   logic [W-1:0] incr_pcin;
   logic [W-1:0] incr_pcout;
   logic [W-1:0] imem_addr;
   logic [W-1:0] if_pc;
   logic [W-1:0] if_npc;
   logic         imem_req;
   logic         instr_valid;
   logic         flush;

   fetch_pc_sequencer #(.WIDTH(W), .RESET_PC('0)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .incr_pcin     (incr_pcin),
      .incr_pcout    (incr_pcout),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .instr_valid   (instr_valid),
      .if_pc         (if_pc),
      .if_npc        (if_npc),
      .flush         (flush)
   );

   // Word incrementer that the sequencer drives.
   assign incr_pcout = incr_pcin + W'(1);

   always #5 clk = ~clk;

   typedef struct {
      logic         req;
      logic [W-1:0] addr;
      logic         valid;
      logic [W-1:0] pc;
      logic [W-1:0] npc;
      logic         flush;
   } exp_t;

   exp_t sb[$];
   exp_t mon;

   int passCount = 0;
   int checkCount = 0;

   // Reference model: where the front end is, what it fetches, and any
   // redirect still waiting for the in-flight access to finish.
   int           mPhase = 0;   // 0 booting, 1 fetching, 2 held
   logic [W-1:0] mPc = '0;
   logic [W-1:0] mPend[$];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checkCount++;
      if (act === req) passCount++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic cyc(input logic r, input logic a, input logic s,
                      input logic j, input logic [W-1:0] jt,
                      input logic b, input logic [W-1:0] bt);
      exp_t         e;
      logic         redir;
      logic [W-1:0] tgt;
      @(posedge clk);
      #1;
      rst = r; imem_ack = a; stall = s;
      jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
      e.req = 1'b0; e.addr = '0; e.valid = 1'b0; e.pc = '0; e.npc = '0; e.flush = 1'b0;
      redir = j || b;
      tgt   = j ? jt : bt;
      if (!r) begin
         mPhase = 0;
         mPc = '0;
         mPend.delete();
      end else if (mPhase == 0) begin
         mPhase = 1;
      end else if (mPhase == 1) begin
         e.req  = 1'b1;
         e.addr = mPc;
         if (!a) begin
            if (redir) begin
               e.flush = 1'b1;
               mPend.delete();
               mPend.push_back(tgt);
            end
         end else if (redir) begin
            e.flush = 1'b1;
            mPc = tgt;
            mPend.delete();
         end else if (mPend.size() > 0) begin
            mPc = mPend.pop_front();
         end else if (s) begin
            mPhase = 2;
         end else begin
            e.valid = 1'b1;
            e.pc    = mPc;
            e.npc   = mPc + 1;
            mPc     = mPc + 1;
         end
      end else begin
         if (redir) begin
            e.flush = 1'b1;
            mPc = tgt;
            mPhase = 1;
         end else if (!s) begin
            mPhase = 1;
         end
      end
      sb.push_back(e);
   endtask

   // Monitor: compare the DUT against the oldest expected record mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon = sb.pop_front();
         chk("imem_req", W'(imem_req), W'(mon.req));
         chk("flush", W'(flush), W'(mon.flush));
         chk("instr_valid", W'(instr_valid), W'(mon.valid));
         if (mon.req) chk("imem_addr", imem_addr, mon.addr);
         if (mon.valid) begin
            chk("if_pc", if_pc, mon.pc);
            chk("if_npc", if_npc, mon.npc);
         end
      end
   end

   initial begin
      logic         r, a, s, j, b;
      logic [W-1:0] jt, bt;

      // Reset, then sequential fetch with ack tied high.
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, 0);
      // One-cycle-late ack per fetch.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0);
         cyc(1, 1, 0, 0, 0, 0, 0);
      end
      // Jump to 15, then a jump to 64 while the access at 15 is outstanding.
      cyc(1, 1, 0, 1, 15, 0, 0);
      cyc(1, 0, 0, 1, 64, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      // Jump and branch together: jump wins.
      cyc(1, 1, 0, 1, 100, 1, 200);
      cyc(1, 1, 0, 0, 0, 0, 0);
      // Stall on ack at pc=8, hold, release, refetch.
      cyc(1, 1, 0, 1, 8, 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      // Branch taken while held.
      cyc(1, 1, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 1, 40);
      cyc(1, 1, 0, 0, 0, 0, 0);
      // Wrap of the top address to 0.
      cyc(1, 1, 0, 1, '1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      // Reset asserted mid-fetch.
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 249) != 0);
         a  = ($urandom_range(0, 99) < 60);
         s  = ($urandom_range(0, 99) < 20);
         j  = ($urandom_range(0, 99) < 8);
         b  = ($urandom_range(0, 99) < 8);
         jt = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom_range(0, 255));
         bt = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom_range(0, 255));
         cyc(r, a, s, j, jt, b, bt);
      end
      cyc(1, 0, 0, 0, 0, 0, 0);

      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
      #1;
      chk("scoreboard_drain", W'(sb.size()), W'(0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
